instr_fetch_buffer: RTL

- Consumer end of the program-counter interface: takes the registered PC each cycle and issues a read to instruction memory.
- Captures the returned instruction, together with the PC that fetched it, into a small FIFO.
- Presents entries to decode over a valid/ready handshake.
- Drives FetchStall back to the PC write-enable so the PC holds whenever buffer space plus in-flight reads are exhausted; Flush discards all wrong-path state on a branch/jump redirect.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch_buffer.sv | 75 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

    localparam int unsigned DEFAULT_ADDR_W  = 32;
    localparam int unsigned DEFAULT_INSTR_W = 32;

    localparam logic [DEFAULT_ADDR_W-1:0]  RESET_VECTOR = 32'h0000_0000;
    localparam logic [DEFAULT_INSTR_W-1:0] NOP_INSTR    = 32'h0000_0000;

    typedef struct packed {
        logic [DEFAULT_INSTR_W-1:0] instr;
        logic [DEFAULT_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic [DEFAULT_INSTR_W-1:0] instr,
                                                input logic [DEFAULT_ADDR_W-1:0]  pc);
        fetch_entry_t e;
        e.instr = instr;
        e.pc    = pc;
        return e;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; clear empties it in one edge, empty head reads as zero.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     rd_entry,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t      mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;
    logic              wipe;

    assign wipe    = Reset || clear;
    assign do_push = push;
    assign do_pop  = pop && (count != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk) begin
        if (wipe) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push && !wipe) mem[wr_ptr] <= wr_entry;
    end

    assign rd_entry = (count == '0) ? '0 : mem[rd_ptr];

    // The upstream stall rule must keep pushes away from a full buffer.
    overflow_check: assert property (@(posedge Clk) disable iff (wipe)
                                     !(push && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/instr_fetch_buffer.sv
// Issues PC reads to instruction memory, queues returned words with their PC,
// and stalls the PC when queued plus in-flight reads would fill the buffer.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH   = 4,
    parameter  int unsigned ADDR_W  = DEFAULT_ADDR_W,
    parameter  int unsigned INSTR_W = DEFAULT_INSTR_W,
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [ADDR_W-1:0]  PCAddress,
    input  logic               PCValid,
    output logic               FetchStall,
    output logic [ADDR_W-1:0]  IMemAddr,
    output logic               IMemRe,
    input  logic [INSTR_W-1:0] IMemData,
    input  logic               Flush,
    output logic [INSTR_W-1:0] InstrOut,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic [CNT_W-1:0]   Count
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic              in_flight;
    logic [ADDR_W-1:0] in_flight_pc;
    logic              issue;
    logic              push;
    logic              pop;
    fetch_entry_t      wr_entry;
    fetch_entry_t      rd_entry;

    // Conservative: a pop in the same cycle frees no space for this cycle's issue.
    assign FetchStall = (SUM_W'(Count) + SUM_W'(in_flight)) >= SUM_W'(DEPTH);

    assign issue    = PCValid && !FetchStall && !Flush && !Reset;
    assign IMemRe   = issue;
    assign IMemAddr = PCAddress;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            in_flight    <= 1'b0;
            in_flight_pc <= '0;
        end else begin
            in_flight <= issue;
            if (issue) in_flight_pc <= PCAddress;
        end
    end

    assign push     = in_flight && !Flush;
    assign pop      = InstrValid && InstrReady;
    assign wr_entry = make_entry(DEFAULT_INSTR_W'(IMemData), DEFAULT_ADDR_W'(in_flight_pc));

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .clear    (Flush),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .count    (Count)
    );

    assign InstrValid = (Count != '0);
    assign InstrOut   = INSTR_W'(rd_entry.instr);
    assign InstrPC    = ADDR_W'(rd_entry.pc);

endmodule
